ysyx_25060170_mdu: RTL and testbench

Iterative multiply/divide unit for the NPC core. It implements the RV32M operations over a parametrised operand width and sits beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready handshake, computes over multiple cycles, and holds the result until the consumer takes it.

---
 rtl/ysyx_25060170_mdu_pkg.sv | 43 ++++
 rtl/ysyx_25060170_mdu_if.sv | 27 ++
 rtl/ysyx_25060170_mdu_step.sv | 33 +++
 rtl/ysyx_25060170_mdu.sv | 155 +++++++++++++++
 tb/tb_ysyx_25060170_mdu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_mdu_pkg.sv
// ysyx_25060170_mdu_pkg: shared types and opcode decode helpers for the
// iterative multiply/divide unit.
package ysyx_25060170_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // First operand is treated as two's complement.
    function automatic logic is_signed_a(mdu_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Second operand is treated as two's complement.
    function automatic logic is_signed_b(mdu_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Any operation that runs through the divider (quotient or remainder).
    function automatic logic is_div(mdu_op_t op);
        return op[2];
    endfunction

    // Divider operations that return the remainder.
    function automatic logic is_rem(mdu_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_25060170_mdu_if.sv
// ysyx_25060170_mdu_if: request/response bundle between the execute stage
// and the multiply/divide unit.
interface ysyx_25060170_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] sr1;
    logic [WIDTH-1:0] sr2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             less;
    logic             busy;

    modport master (
        output in_valid, opcode, sr1, sr2, out_ready,
        input  in_ready, out_valid, res, zero, less, busy
    );

    modport slave (
        input  in_valid, opcode, sr1, sr2, out_ready,
        output in_ready, out_valid, res, zero, less, busy
    );
endinterface

// File: rtl/ysyx_25060170_mdu_step.sv
// ysyx_25060170_mdu_step: one radix-2 iteration, purely combinational.
// Multiply: acc = {partial_high, remaining_multiplier}, opnd = multiplicand.
// Divide:   acc = {partial_remainder, remaining_dividend/quotient}, opnd = divisor.
module ysyx_25060170_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shl;
    logic [WIDTH:0]     diff;

    // Shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shl      = {acc[2*WIDTH-2:0], 1'b0};
        // The bit shifted out of the top keeps the partial remainder exact.
        diff     = {acc[2*WIDTH-1], shl[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
        acc_next = shl;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/ysyx_25060170_mdu.sv
// ysyx_25060170_mdu: iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes on accept, iterated for WIDTH cycles,
// then sign-corrected in a single FIX cycle.
// Optional macro YSYX_25060170_MDU_FLUSH_EN adds a 'flush' port that aborts
// any in-flight operation.
module ysyx_25060170_mdu
    import ysyx_25060170_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef YSYX_25060170_MDU_FLUSH_EN
    input  logic flush,
`endif
    ysyx_25060170_mdu_if.slave bus
);
    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d, op_in;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d, res_q, res_d, fix_res;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic               a_neg, b_neg, div_zero, div_ovf, flush_w;

`ifdef YSYX_25060170_MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    ysyx_25060170_mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div(op_q)),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc)
    );

    // Sign correction and half selection applied in FIX.
    always_comb begin
        prod = neg_quo_q ? -acc_q : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:               fix_res = prod[WIDTH-1:0];
            OP_DIV, OP_DIVU:      fix_res = neg_quo_q ? -quo : quo;
            OP_REM, OP_REMU:      fix_res = neg_rem_q ? -rem : rem;
            default:              fix_res = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    // Next-state logic: accept/fast path, iteration, fix-up and hand-off.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        op_in    = mdu_op_t'(bus.opcode);
        a_neg    = is_signed_a(op_in) & bus.sr1[WIDTH-1];
        b_neg    = is_signed_b(op_in) & bus.sr2[WIDTH-1];
        a_mag    = a_neg ? -bus.sr1 : bus.sr1;
        b_mag    = b_neg ? -bus.sr2 : bus.sr2;
        div_zero = (bus.sr2 == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (bus.sr1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.sr2 == '1);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !flush_w) begin
                    op_d = op_in;
                    if (is_div(op_in) && div_zero) begin
                        res_d   = is_rem(op_in) ? bus.sr1 : '1;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = is_rem(op_in) ? '0 : bus.sr1;
                        state_d = ST_DONE;
                    end else begin
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(WIDTH);
                        if (is_div(op_in)) begin
                            acc_d  = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (flush_w || bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.res       = res_q;
    assign bus.zero      = (res_q == '0);
    assign bus.less      = res_q[WIDTH-1];
endmodule

// File: tb/tb_ysyx_25060170_mdu.sv
// tb_ysyx_25060170_mdu: directed and random checks of the multiply/divide
// unit against a plain-arithmetic reference model (WIDTH = 32).
module tb_ysyx_25060170_mdu;
    logic clk;
    logic rst_n;
`ifdef YSYX_25060170_MDU_FLUSH_EN
    logic flush;
`endif
    int errors;
    int checks;

    ysyx_25060170_mdu_if #(.WIDTH(32)) bus ();

    ysyx_25060170_mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef YSYX_25060170_MDU_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mdu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp_v;
        int          lat;
        int          exp_lat;
        bit          fast;
        exp_v   = ref_mdu(op, a, b);
        fast    = op[2] && (b == 32'd0 ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = fast ? 1 : 34;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.sr1      = a;
        bus.sr2      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 3'($urandom);
        bus.sr1      = $urandom;
        bus.sr2      = $urandom;
        if (!fast) chk("busy_calc", {31'd0, bus.busy}, 32'd1);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("res", bus.res, exp_v);
        chk("zero", {31'd0, bus.zero}, {31'd0, exp_v == 32'd0});
        chk("less", {31'd0, bus.less}, {31'd0, exp_v[31]});
        chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_res", bus.res, exp_v);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("release_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("op=%0d a=%h b=%h res=%h expect=%h lat=%0d", op, a, b, bus.res, exp_v, lat);
    endtask

    task automatic chk_idle_reset;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_res", bus.res, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("rst_less", {31'd0, bus.less}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        logic [31:0] saved;
        int          pulses;
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = 3'd0;
        bus.sr1       = 32'd0;
        bus.sr2       = 32'd0;
`ifdef YSYX_25060170_MDU_FLUSH_EN
        flush         = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_idle_reset();

        // Directed cases from the operation table.
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd5, 32'd100, 32'd7, 0);
        do_op(3'd7, 32'd100, 32'd7, 0);
        do_op(3'd5, 32'd5, 32'd0, 0);
        do_op(3'd6, 32'd5, 32'd0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Backpressure: consumer stalls for 10 cycles in DONE.
        do_op(3'd0, 32'd123, 32'd456, 10);

        // Reset in the middle of an iteration discards the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd0;
        bus.sr1      = 32'd9;
        bus.sr2      = 32'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_rst", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_idle_reset();
        $display("reset mid-CALC res=%h", bus.res);

`ifdef YSYX_25060170_MDU_FLUSH_EN
        // Flush in CALC abandons the operation without a result.
        do_op(3'd7, 32'd50, 32'd7, 0);
        saved = bus.res;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd0;
        bus.sr1      = 32'd1000;
        bus.sr2      = 32'd1000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_res", bus.res, saved);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        chk("flush_no_valid", 32'(pulses), 32'd0);
        $display("flush mid-CALC res=%h", bus.res);
        do_op(3'd0, 32'd3, 32'd4, 0);
`else
        saved  = 32'd0;
        pulses = 0;
`endif

        // Random operations, biased towards divider corner cases.
        for (int i = 0; i < 48; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(rop, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
